// File: rtl/pb_port_pkg.sv
// Shared definitions for the PicoBlaze port responder: port addresses,
// STATUS/CTRL bit positions and the timer state encoding.
package pb_port_pkg;

   // Port addresses (exact match on port_id)
   localparam logic [7:0] PB_PORT_STATUS    = 8'h00;
   localparam logic [7:0] PB_PORT_DATA      = 8'h01;
   localparam logic [7:0] PB_PORT_RELOAD_LO = 8'h02;
   localparam logic [7:0] PB_PORT_RELOAD_HI = 8'h03;
   localparam logic [7:0] PB_PORT_CTRL      = 8'h04;
   localparam logic [7:0] PB_PORT_LED       = 8'h05;

   // STATUS bit positions
   localparam int unsigned STATUS_TIMER_EVT  = 0;
   localparam int unsigned STATUS_FIFO_EMPTY = 1;
   localparam int unsigned STATUS_FIFO_FULL  = 2;
   localparam int unsigned STATUS_OVERFLOW   = 3;

   // CTRL bit positions; CLR_* bits are write-one actions, not stored
   localparam int unsigned CTRL_TIMER_EN    = 0;
   localparam int unsigned CTRL_FIFO_IRQ_EN = 1;
   localparam int unsigned CTRL_CLR_OVF     = 2;
   localparam int unsigned CTRL_CLR_EVT     = 3;

   // Timer state encoding
   localparam logic [0:0] TMR_IDLE  = 1'b0;
   localparam logic [0:0] TMR_COUNT = 1'b1;

endpackage

// File: rtl/pb_byte_fifo.sv
// Small byte FIFO with registered head/tail pointers and occupancy count.
// DEPTH must be a power of two (pointers wrap by natural overflow), >= 2.
// Pushes when full and pops when empty are ignored.
module pb_byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Occupancy next-state
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers and count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/pb_port_responder.sv
// PicoBlaze I/O responder: STATUS/DATA/RELOAD/CTRL/LED ports, 4-deep input
// byte FIFO, interval timer and a sticky interrupt cleared by interrupt_ack.
// Build option: define PB_PORT_READBACK_EN to make ports 0x02-0x05 readable.
module pb_port_responder
   import pb_port_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 25000000,
   parameter int unsigned TICK_HZ     = 1000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] port_id,
   input  logic       write_strobe,
   input  logic       read_strobe,
   input  logic [7:0] out_port,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic       src_valid,
   input  logic [7:0] src_data,
   output logic       src_ready,
   output logic [7:0] led
);

   localparam int unsigned PRESC_TC = CLK_FREQ_HZ / TICK_HZ - 1;
   localparam int unsigned PRESC_W  = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

   // Register file
   logic [7:0]  led_q;
   logic [15:0] reload_q;
   logic        timer_en_q, fifo_irq_en_q;
   logic        overflow_q, timer_evt_q;
   logic [7:0]  in_port_q;
   logic        irq_q, irq_cond_q;

   // Timer
   logic [0:0]         tmr_state_q, tmr_state_d;
   logic [15:0]        tmr_cnt_q, tmr_cnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               tick, evt_set;

   // FIFO
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_head;
   logic [CNT_W-1:0] fifo_count;

   logic       wr_reload_lo, wr_reload_hi, wr_ctrl, wr_led, rd_data_port;
   logic       irq_cond;
   logic [7:0] rd_data;

   assign wr_reload_lo = write_strobe & (port_id == PB_PORT_RELOAD_LO);
   assign wr_reload_hi = write_strobe & (port_id == PB_PORT_RELOAD_HI);
   assign wr_ctrl      = write_strobe & (port_id == PB_PORT_CTRL);
   assign wr_led       = write_strobe & (port_id == PB_PORT_LED);
   assign rd_data_port = read_strobe & (port_id == PB_PORT_DATA);

   assign src_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
   assign fifo_push = src_valid & src_ready;
   // Empty-pop is dropped; a same-cycle push into an empty FIFO still lands
   assign fifo_pop  = rd_data_port & ~fifo_empty;

   pb_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (src_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Processor-writable configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reload_q      <= 16'h0000;
         timer_en_q    <= 1'b0;
         fifo_irq_en_q <= 1'b0;
         led_q         <= 8'h00;
      end else begin
         if (wr_reload_lo) reload_q[7:0]  <= out_port;
         if (wr_reload_hi) reload_q[15:8] <= out_port;
         if (wr_ctrl) begin
            timer_en_q    <= out_port[CTRL_TIMER_EN];
            fifo_irq_en_q <= out_port[CTRL_FIFO_IRQ_EN];
         end
         if (wr_led) led_q <= out_port;
      end
   end

   // Sticky flags; a set event beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q  <= 1'b0;
         timer_evt_q <= 1'b0;
      end else begin
         if (src_valid & ~src_ready)                 overflow_q <= 1'b1;
         else if (wr_ctrl & out_port[CTRL_CLR_OVF])  overflow_q <= 1'b0;
         if (evt_set)                                timer_evt_q <= 1'b1;
         else if (wr_ctrl & out_port[CTRL_CLR_EVT])  timer_evt_q <= 1'b0;
      end
   end

   assign tick = (presc_q == PRESC_W'(PRESC_TC));

   // Timer next-state: reload ticks per event, reload sampled at each wrap
   always_comb begin
      tmr_state_d = tmr_state_q;
      tmr_cnt_d   = tmr_cnt_q;
      presc_d     = presc_q;
      evt_set     = 1'b0;
      case (tmr_state_q)
         TMR_IDLE: begin
            if (timer_en_q && (reload_q != 16'h0000)) begin
               tmr_state_d = TMR_COUNT;
               tmr_cnt_d   = reload_q;
               presc_d     = '0;
            end
         end
         TMR_COUNT: begin
            if (!timer_en_q || (reload_q == 16'h0000)) begin
               tmr_state_d = TMR_IDLE;
            end else if (tick) begin
               presc_d = '0;
               if (tmr_cnt_q == 16'd1) begin
                  evt_set   = 1'b1;
                  tmr_cnt_d = reload_q;
               end else begin
                  tmr_cnt_d = tmr_cnt_q - 16'd1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: tmr_state_d = TMR_IDLE;
      endcase
   end

   // Timer state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_state_q <= TMR_IDLE;
         tmr_cnt_q   <= 16'h0000;
         presc_q     <= '0;
      end else begin
         tmr_state_q <= tmr_state_d;
         tmr_cnt_q   <= tmr_cnt_d;
         presc_q     <= presc_d;
      end
   end

   assign irq_cond = timer_evt_q | (fifo_irq_en_q & ~fifo_empty);

   // Interrupt: set on rising edge of the request, cleared by ack (set wins)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_cond_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_cond_q <= irq_cond;
         if (irq_cond & ~irq_cond_q) irq_q <= 1'b1;
         else if (interrupt_ack)     irq_q <= 1'b0;
      end
   end

   // Read-data decode from the current port_id
   always_comb begin
      rd_data = 8'h00;
      case (port_id)
         PB_PORT_STATUS: begin
            rd_data[STATUS_TIMER_EVT]  = timer_evt_q;
            rd_data[STATUS_FIFO_EMPTY] = fifo_empty;
            rd_data[STATUS_FIFO_FULL]  = fifo_full;
            rd_data[STATUS_OVERFLOW]   = overflow_q;
         end
         PB_PORT_DATA: rd_data = fifo_empty ? 8'h00 : fifo_head;
`ifdef PB_PORT_READBACK_EN
         PB_PORT_RELOAD_LO: rd_data = reload_q[7:0];
         PB_PORT_RELOAD_HI: rd_data = reload_q[15:8];
         PB_PORT_CTRL:      rd_data = {6'b000000, fifo_irq_en_q, timer_en_q};
         PB_PORT_LED:       rd_data = led_q;
`endif
         default: rd_data = 8'h00;
      endcase
   end

   // Registered read path: one cycle from port_id to in_port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_port_q <= 8'h00;
      else          in_port_q <= rd_data;
   end

   assign in_port   = in_port_q;
   assign interrupt = irq_q;
   assign led       = led_q;

endmodule

// File: tb/tb_pb_port_responder.sv
// Self-checking bench for pb_port_responder: a transaction-level model
// (queue FIFO, elapsed-cycle timer) checked every cycle, plus directed
// vectors with hand-computed expectations.
module tb_pb_port_responder;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned TICKS_PER = 10;  // CLK_FREQ_HZ / TICK_HZ below

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] port_id = 8'h00;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] out_port = 8'h00;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;
   logic       src_valid = 1'b0;
   logic [7:0] src_data = 8'h00;
   logic       src_ready;
   logic [7:0] led;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit run_cmp  = 1'b0;

   pb_port_responder #(
      .CLK_FREQ_HZ (100),
      .TICK_HZ     (10),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .port_id       (port_id),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .out_port      (out_port),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .src_valid     (src_valid),
      .src_data      (src_data),
      .src_ready     (src_ready),
      .led           (led)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   logic [7:0]  m_fifo[$];
   logic        m_ovf, m_evt, m_en, m_irqen, m_int, m_cond_prev, m_run;
   logic [15:0] m_reload;
   logic [7:0]  m_led, m_inport;
   int          m_elapsed, m_period;

   task automatic model_reset();
      m_fifo.delete();
      m_ovf = 0; m_evt = 0; m_en = 0; m_irqen = 0; m_int = 0; m_cond_prev = 0;
      m_run = 0; m_reload = 16'h0000; m_led = 8'h00; m_inport = 8'h00;
      m_elapsed = 0; m_period = 0;
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] addr);
      logic [7:0] v;
      v = 8'h00;
      case (addr)
         8'h00: v = {4'h0, m_ovf, (m_fifo.size() == DEPTH), (m_fifo.size() == 0), m_evt};
         8'h01: v = (m_fifo.size() == 0) ? 8'h00 : m_fifo[0];
`ifdef PB_PORT_READBACK_EN
         8'h02: v = m_reload[7:0];
         8'h03: v = m_reload[15:8];
         8'h04: v = {6'h00, m_irqen, m_en};
         8'h05: v = m_led;
`endif
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   task automatic model_step();
      logic empty, full, cond, pop, push, evt_hit, n_int, wr_ctrl;
      logic [7:0] rd;
      empty   = (m_fifo.size() == 0);
      full    = (m_fifo.size() == DEPTH);
      cond    = m_evt | (m_irqen & !empty);
      rd      = model_read(port_id);
      pop     = read_strobe && (port_id == 8'h01) && !empty;
      push    = src_valid && !full;
      wr_ctrl = write_strobe && (port_id == 8'h04);
      if (cond && !m_cond_prev) n_int = 1'b1;
      else if (interrupt_ack)   n_int = 1'b0;
      else                      n_int = m_int;
      // Timer: one event every reload*TICKS_PER cycles after start
      evt_hit = 1'b0;
      if (!m_run) begin
         if (m_en && m_reload != 0) begin
            m_run = 1; m_elapsed = 0; m_period = int'(m_reload) * TICKS_PER;
         end
      end else if (!m_en || m_reload == 0) begin
         m_run = 0;
      end else begin
         m_elapsed++;
         if (m_elapsed == m_period) begin
            evt_hit = 1; m_elapsed = 0; m_period = int'(m_reload) * TICKS_PER;
         end
      end
      if (evt_hit) m_evt = 1;
      else if (wr_ctrl && out_port[3]) m_evt = 0;
      if (src_valid && full) m_ovf = 1;
      else if (wr_ctrl && out_port[2]) m_ovf = 0;
      if (wr_ctrl) begin m_en = out_port[0]; m_irqen = out_port[1]; end
      if (write_strobe && port_id == 8'h02) m_reload[7:0]  = out_port;
      if (write_strobe && port_id == 8'h03) m_reload[15:8] = out_port;
      if (write_strobe && port_id == 8'h05) m_led = out_port;
      if (pop)  void'(m_fifo.pop_front());
      if (push) m_fifo.push_back(src_data);
      m_cond_prev = cond;
      m_int       = n_int;
      m_inport    = rd;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else          model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && run_cmp) begin
            check("model in_port", 32'(in_port), 32'(m_inport));
            check("model interrupt", 32'(interrupt), 32'(m_int));
            check("model led", 32'(led), 32'(m_led));
            check("model src_ready", 32'(src_ready), 32'(m_fifo.size() != DEPTH));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id = addr; out_port = data; write_strobe = 1'b1;
      step();
      write_strobe = 1'b0;
   endtask

   // port_id held two cycles, strobe on the second; data sampled at strobe
   task automatic rd(input logic [7:0] addr, output logic [7:0] data);
      port_id = addr;
      step();
      read_strobe = 1'b1;
      @(negedge clk);
      data = in_port;
      step();
      read_strobe = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      src_valid = 1'b1; src_data = b;
      step();
      src_valid = 1'b0;
   endtask

   task automatic wait_irq(input int limit, output int at);
      int n;
      n = 0;
      while (interrupt !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      at = cyc;
      if (n >= limit) check("interrupt timeout", 32'(interrupt), 32'd1);
   endtask

   logic [7:0] d;
   int t_en, t1, t2;

   initial begin
      repeat (3) step();
      reset_n = 1'b1;
      step();
      run_cmp = 1'b1;

      // Reset state
      rd(8'h00, d);  check("reset STATUS", 32'(d), 32'h02);
      check("reset interrupt", 32'(interrupt), 32'd0);
      check("reset led", 32'(led), 32'h00);
      check("reset src_ready", 32'(src_ready), 32'd1);

      // FIFO ordering and full/empty
      push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
      check("full src_ready", 32'(src_ready), 32'd0);
      rd(8'h00, d);  check("full STATUS", 32'(d), 32'h04);
      rd(8'h01, d);  check("pop 1", 32'(d), 32'hA1);
      rd(8'h01, d);  check("pop 2", 32'(d), 32'hB2);
      rd(8'h01, d);  check("pop 3", 32'(d), 32'hC3);
      rd(8'h01, d);  check("pop 4", 32'(d), 32'hD4);
      rd(8'h00, d);  check("drained STATUS", 32'(d), 32'h02);
      rd(8'h01, d);  check("empty pop", 32'(d), 32'h00);

      // Overflow: 0xEE offered while full is dropped
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      src_valid = 1'b1; src_data = 8'hEE;
      repeat (3) step();
      src_valid = 1'b0;
      rd(8'h00, d);  check("overflow STATUS", 32'(d), 32'h0C);
      rd(8'h01, d);  check("ovf pop 1", 32'(d), 32'h11);
      rd(8'h01, d);  check("ovf pop 2", 32'(d), 32'h22);
      rd(8'h01, d);  check("ovf pop 3", 32'(d), 32'h33);
      rd(8'h01, d);  check("ovf pop 4", 32'(d), 32'h44);
      rd(8'h00, d);  check("ovf empty STATUS", 32'(d), 32'h0A);
      wr(8'h04, 8'h04);
      rd(8'h00, d);  check("ovf cleared STATUS", 32'(d), 32'h02);

      // Ack collides with a new FIFO-not-empty edge: set wins
      wr(8'h04, 8'h02);
      repeat (2) step();
      src_valid = 1'b1; src_data = 8'h5C;
      step();
      src_valid = 1'b0; interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("ack collision interrupt", 32'(interrupt), 32'd1);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("plain ack interrupt", 32'(interrupt), 32'd0);
      rd(8'h01, d);  check("collision byte", 32'(d), 32'h5C);
      wr(8'h04, 8'h00);

      // Timer: reload 3 ticks of 10 clocks = 30-clock period
      wr(8'h02, 8'h03);
      wr(8'h03, 8'h00);
      wr(8'h04, 8'h01);
      t_en = cyc;
      wait_irq(200, t1);
      // 30-clock period plus start-up and interrupt register latency
      check("timer first rise window", 32'((t1 - t_en) >= 30 && (t1 - t_en) <= 32), 32'd1);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      wr(8'h04, 8'h09);  // keep enabled, clear timer_evt
      check("after ack+clear interrupt", 32'(interrupt), 32'd0);
      wait_irq(200, t2);
      check("timer period", 32'(t2 - t1), 32'd30);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      wr(8'h04, 8'h08);
      repeat (45) step();
      check("timer stopped interrupt", 32'(interrupt), 32'd0);

      // LED register and readback option
      wr(8'h05, 8'h5A);
      check("led write", 32'(led), 32'h5A);
      wr(8'h09, 8'hFF);
      check("unmapped write ignored", 32'(led), 32'h5A);
      rd(8'h05, d);
`ifdef PB_PORT_READBACK_EN
      check("LED readback", 32'(d), 32'h5A);
      rd(8'h02, d);  check("RELOAD_LO readback", 32'(d), 32'h03);
`else
      check("LED readback", 32'(d), 32'h00);
      rd(8'h02, d);  check("RELOAD_LO readback", 32'(d), 32'h00);
`endif
      rd(8'h07, d);  check("unmapped read", 32'(d), 32'h00);

      // Reset mid-operation drops FIFO contents and interrupt
      push(8'h77); push(8'h88);
      wr(8'h04, 8'h02);
      repeat (2) step();
      check("pre-reset interrupt", 32'(interrupt), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid reset interrupt", 32'(interrupt), 32'd0);
      check("mid reset led", 32'(led), 32'h00);
      check("mid reset src_ready", 32'(src_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      rd(8'h00, d);  check("post reset STATUS", 32'(d), 32'h02);
      rd(8'h01, d);  check("post reset DATA", 32'(d), 32'h00);

      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
